// File: rtl/module_rca_arbiter.sv
// rtl/module_rca_arbiter.sv - two-requester arbiter sharing one ripple-carry adder
//
// module_rca_8bits : WIDTH-bit combinational ripple-carry adder
//   a, b  in  WIDTH   operands
//   cin   in  1       carry in
//   sum   out WIDTH   sum bits
//   cout  out 1       carry out
//
// module_rca_arbiter : arbitrates two level requests onto a single adder,
// holds the winner's operands for SETTLE_CYCLES, registers the sum.
//   clk_pi     in   1        clock, rising edge
//   rst_n_pi   in   1        asynchronous active-low reset
//   req_pi     in   2        level request per requester
//   a0_pi      in   WIDTH    operand A, requester 0
//   b0_pi      in   WIDTH    operand B, requester 0
//   a1_pi      in   WIDTH    operand A, requester 1
//   b1_pi      in   WIDTH    operand B, requester 1
//   gnt_po     out  2        one-hot grant, operands sampled this cycle
//   done_po    out  2        one-hot completion pulse
//   result_po  out  WIDTH+1  registered sum, held after done
//   busy_po    out  1        high whenever not idle
//
// Build option: RCA_ARB_FIXED_PRIO_EN selects fixed priority (requester 0
// wins ties) instead of round robin.

module module_rca_8bits #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            assign sum[i]     = a[i] ^ b[i] ^ carry[i];
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule

module module_rca_arbiter #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk_pi,
    input  logic             rst_n_pi,
    input  logic [1:0]       req_pi,
    input  logic [WIDTH-1:0] a0_pi,
    input  logic [WIDTH-1:0] b0_pi,
    input  logic [WIDTH-1:0] a1_pi,
    input  logic [WIDTH-1:0] b1_pi,
    output logic [1:0]       gnt_po,
    output logic [1:0]       done_po,
    output logic [WIDTH:0]   result_po,
    output logic             busy_po
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             win;
    logic             pick;
    logic [3:0]       cnt;
    logic             exec_last;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] rca_sum;
    logic             rca_cout;
    logic [1:0]       win_oh;

`ifdef RCA_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it asks.
    assign pick = ~req_pi[0];
`else
    logic rr_last;

    // On a tie the requester that did not go last wins; otherwise whoever asks.
    assign pick = (req_pi == 2'b11) ? ~rr_last : req_pi[1];
`endif

    assign win_oh    = {win, ~win};
    assign exec_last = (cnt == 4'(SETTLE_CYCLES - 1));

    module_rca_8bits #(
        .WIDTH (WIDTH)
    ) u_rca (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_po    = 2'b00;
        done_po   = 2'b00;
        busy_po   = 1'b1;
        case (state)
            IDLE: begin
                busy_po = 1'b0;
                if (req_pi != 2'b00) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                gnt_po    = win_oh;
                state_nxt = EXEC;
            end
            EXEC: begin
                if (exec_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_po   = win_oh;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: the winner is frozen at the IDLE->LOAD edge so that grant,
    // operand capture and done all refer to the same requester.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            win       <= 1'b0;
            cnt       <= 4'd0;
            op_a      <= '0;
            op_b      <= '0;
            result_po <= '0;
`ifndef RCA_ARB_FIXED_PRIO_EN
            rr_last   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_pi != 2'b00) begin
                        win <= pick;
                    end
                end
                LOAD: begin
                    op_a <= win ? a1_pi : a0_pi;
                    op_b <= win ? b1_pi : b0_pi;
                    cnt  <= 4'd0;
`ifndef RCA_ARB_FIXED_PRIO_EN
                    rr_last <= win;
`endif
                end
                EXEC: begin
                    if (exec_last) begin
                        result_po <= {rca_cout, rca_sum};
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_rca_arbiter.sv
// tb/tb_module_rca_arbiter.sv - self-checking bench for module_rca_arbiter
module tb_module_rca_arbiter;

`ifdef RCA_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif
    localparam int S = 1;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] a0, b0, a1, b1;
    logic [1:0] gnt, done;
    logic [8:0] result;
    logic       busy;

    logic [1:0] req4;
    logic [7:0] a04, b04, a14, b14;
    logic [1:0] gnt4, done4;
    logic [8:0] result4;
    logic       busy4;

    int checks = 0;
    int errors = 0;
    int rr_last_m = 1;

    module_rca_arbiter #(.WIDTH(8), .SETTLE_CYCLES(S)) dut (
        .clk_pi(clk), .rst_n_pi(rst_n), .req_pi(req),
        .a0_pi(a0), .b0_pi(b0), .a1_pi(a1), .b1_pi(b1),
        .gnt_po(gnt), .done_po(done), .result_po(result), .busy_po(busy)
    );

    module_rca_arbiter #(.WIDTH(8), .SETTLE_CYCLES(4)) dut4 (
        .clk_pi(clk), .rst_n_pi(rst_n), .req_pi(req4),
        .a0_pi(a04), .b0_pi(b04), .a1_pi(a14), .b1_pi(b14),
        .gnt_po(gnt4), .done_po(done4), .result_po(result4), .busy_po(busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Grant and done are never both active and each is one-hot or zero.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (((gnt & done) != 2'b00) || !$onehot0(gnt) || !$onehot0(done)) begin
                errors++;
                $display("FAIL onehot_excl: got gnt=%b done=%b required exclusive one-hot", gnt, done);
            end
        end
    end

    // Reference arbitration from the rules: ties go to the requester that
    // did not win last (or always to 0 with fixed priority); a lone request wins.
    function automatic int model_win(input logic [1:0] r);
        if (r == 2'b11) return FIXED_PRIO ? 0 : 1 - rr_last_m;
        return r[1] ? 1 : 0;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rr_last_m = 1;
    endtask

    task automatic run_op(input string name, input logic [1:0] r,
                          input logic [7:0] xa0, input logic [7:0] xb0,
                          input logic [7:0] xa1, input logic [7:0] xb1,
                          input int w, input logic [8:0] res);
        logic [1:0] oh;
        oh = (w == 1) ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        req = r; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
        @(negedge clk);
        chk({name, "/idle_busy"}, busy, 0);
        @(negedge clk);
        chk({name, "/gnt"}, gnt, oh);
        chk({name, "/busy_load"}, busy, 1);
        @(posedge clk); #1;
        req = 2'b00;
        a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        repeat (S) begin
            @(negedge clk);
            chk({name, "/exec_quiet"}, {gnt, done, busy}, 5'b00001);
        end
        @(negedge clk);
        chk({name, "/done"}, done, oh);
        chk({name, "/result"}, result, res);
        @(negedge clk);
        chk({name, "/idle_after"}, {done, busy}, 3'b000);
        chk({name, "/result_held"}, result, res);
    endtask

    typedef struct {
        logic [1:0] r;
        logic [7:0] xa0, xb0, xa1, xb1;
        int         w_rr, w_fp;
        logic [8:0] res_rr, res_fp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        rst_n = 1'b0;
        req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        req4 = 2'b00; a04 = '0; b04 = '0; a14 = '0; b14 = '0;

        vecs[0] = '{2'b01, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0, 9'h1FE, 9'h1FE};
        vecs[1] = '{2'b11, 8'h01, 8'h02, 8'h80, 8'h80, 1, 0, 9'h100, 9'h003};
        vecs[2] = '{2'b11, 8'h01, 8'h02, 8'h80, 8'h80, 0, 0, 9'h003, 9'h003};
        vecs[3] = '{2'b10, 8'h12, 8'h34, 8'hFF, 8'h01, 1, 1, 9'h100, 9'h100};
        vecs[4] = '{2'b11, 8'h7F, 8'h7F, 8'h00, 8'h00, 0, 0, 9'h0FE, 9'h0FE};
        vecs[5] = '{2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 9'h000, 9'h000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {gnt, done, busy, result}, 0);
        chk("reset_outputs4", {gnt4, done4, busy4, result4}, 0);
        rst_n = 1'b1;
        rr_last_m = 1;

        for (int i = 0; i < 6; i++) begin
            int w;
            w = FIXED_PRIO ? vecs[i].w_fp : vecs[i].w_rr;
            run_op($sformatf("vec%0d", i), vecs[i].r, vecs[i].xa0, vecs[i].xb0,
                   vecs[i].xa1, vecs[i].xb1, w,
                   FIXED_PRIO ? vecs[i].res_fp : vecs[i].res_rr);
            rr_last_m = w;
        end

        for (int i = 0; i < 30; i++) begin
            logic [1:0] r;
            logic [7:0] xa0, xb0, xa1, xb1;
            int w, s;
            r   = 2'($urandom_range(1, 3));
            xa0 = 8'($urandom); xb0 = 8'($urandom);
            xa1 = 8'($urandom); xb1 = 8'($urandom);
            w   = model_win(r);
            s   = (w == 1) ? int'(xa1) + int'(xb1) : int'(xa0) + int'(xb0);
            run_op($sformatf("rand%0d", i), r, xa0, xb0, xa1, xb1, w, 9'(s));
            rr_last_m = w;
        end

        // Held tie: alternates under round robin, stays on 0 with fixed priority.
        do_reset();
        req = 2'b11; a0 = 8'h01; b0 = 8'h02; a1 = 8'h80; b1 = 8'h80;
        begin
            int cyc, last_cyc, k, found;
            cyc = 0; last_cyc = 0;
            for (k = 0; k < 7; k++) begin
                int w;
                if (k == 6) begin
                    @(posedge clk); #1;
                    req = 2'b10;
                end
                found = 0;
                for (int c = 0; c < 20 && found == 0; c++) begin
                    @(negedge clk);
                    cyc++;
                    if (done != 2'b00) found = 1;
                end
                chk($sformatf("held%0d/seen", k), found, 1);
                w = (k == 6) ? 1 : (FIXED_PRIO ? 0 : k % 2);
                chk($sformatf("held%0d/done", k), done, (w == 1) ? 2'b10 : 2'b01);
                chk($sformatf("held%0d/result", k), result, (w == 1) ? 9'h100 : 9'h003);
                if (k > 0 && k < 6) chk($sformatf("held%0d/period", k), cyc - last_cyc, 3 + S);
                last_cyc = cyc;
            end
            @(posedge clk); #1;
            req = 2'b00;
            repeat (2) @(negedge clk);
            chk("held/idle", busy, 0);
        end

        // Reset in the middle of an operation discards it.
        @(posedge clk); #1;
        req = 2'b01; a0 = 8'h10; b0 = 8'h20;
        @(posedge clk);
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk);
        chk("rst_mid/in_exec", {gnt, done, busy}, 5'b00001);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid/outputs", {gnt, done, busy, result}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid/no_done", done, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rr_last_m = 1;
        run_op("post_rst", 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 0, 9'h000);

        // A req[1] pulse confined to the busy window is never granted.
        @(posedge clk); #1;
        req = 2'b01; a0 = 8'h05; b0 = 8'h06;
        @(negedge clk);
        @(negedge clk);
        chk("pulse/gnt", gnt, 2'b01);
        @(posedge clk); #1;
        req = 2'b10;
        @(negedge clk);
        chk("pulse/exec_gnt", gnt, 0);
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk);
        chk("pulse/done", done, 2'b01);
        chk("pulse/result", result, 9'h00B);
        repeat (4) begin
            @(negedge clk);
            chk("pulse/ignored", {gnt, busy}, 3'b000);
        end

        // SETTLE_CYCLES=4 instance: done in cycle 6, late operand change ignored.
        @(posedge clk); #1;
        req4 = 2'b01; a04 = 8'h7F; b04 = 8'h01;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            logic [1:0] eg, ed;
            logic       eb;
            @(posedge clk); #1;
            if (cyc == 2) begin
                req4 = 2'b00;
                a04  = 8'h00;
            end
            @(negedge clk);
            eg = (cyc == 1) ? 2'b01 : 2'b00;
            ed = (cyc == 6) ? 2'b01 : 2'b00;
            eb = (cyc <= 6);
            chk($sformatf("settle4/cyc%0d", cyc), {gnt4, done4, busy4}, {eg, ed, eb});
            if (cyc == 6) chk("settle4/result", result4, 9'h080);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
